// File: rtl/brief_engine_tm.sv
// brief_engine_tm: time-multiplexed, steered BRIEF descriptor engine.
// Takes one keypoint job at a time. It fetches LANES test pairs per beat from an
// external synchronous pattern ROM, rotates them by the job's sin/cos, and
// compares pixel pairs in the latched window. The DESC_BITS descriptor is
// built over BEATS beats and handed off over a valid/ready handshake.
module brief_engine_tm #(
    parameter int PATCH     = 31,
    parameter int DESC_BITS = 256,
    parameter int LANES     = 32,
    parameter int TRIG_W    = 12,
    parameter int FRAC      = 10,
    parameter int X_OFFSET  = 2,
    parameter int BEATS     = DESC_BITS / LANES
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst_n,
    input  logic                                       i_valid,
    output logic                                       o_ready,
    input  logic [PATCH*PATCH*8-1:0]                   i_window,
    input  logic [9:0]                                 i_coor_x,
    input  logic [9:0]                                 i_coor_y,
    input  logic [7:0]                                 i_score,
    input  logic signed [TRIG_W-1:0]                   i_sin,
    input  logic signed [TRIG_W-1:0]                   i_cos,
    input  logic                                       i_rot_en,
    output logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] o_pat_addr,
    input  logic [LANES*32-1:0]                        i_pat,
    output logic                                       o_valid,
    input  logic                                       i_ready,
    output logic [9:0]                                 o_coor_x,
    output logic [9:0]                                 o_coor_y,
    output logic [7:0]                                 o_score,
    output logic [DESC_BITS-1:0]                       o_descriptor
);

    localparam int PAT_AW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RAD    = (PATCH - 1) / 2;
    localparam int CW     = $clog2(PATCH);
    localparam int WIN_W  = PATCH * PATCH * 8;
    localparam int WAW    = $clog2(WIN_W);
    localparam int DW     = (DESC_BITS > 1) ? $clog2(DESC_BITS) : 1;
    localparam int PW     = 8 + TRIG_W;
    // Rotated coordinates stay within about +/-2^(PW-FRAC). Two extra bits cover
    // the sum and the sign, and 10 bits is the floor.
    localparam int IW     = (PW - FRAC + 3 > 10) ? (PW - FRAC + 3) : 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic signed [IW-1:0] RAD_S  = IW'(RAD);
    localparam logic signed [IW-1:0] PMAX_S = IW'(PATCH - 1);
    localparam logic signed [PW-1:0] RND_S  = PW'((1 << FRAC) - 1);

    // Q(FRAC) product of a pattern coordinate and sin/cos, truncated toward zero.
    function automatic logic signed [IW-1:0] mul_trunc(input logic signed [7:0] c,
                                                       input logic signed [TRIG_W-1:0] t);
        logic signed [PW-1:0] p;
        p = PW'(c) * PW'(t);
        if (p < 0) p = p + RND_S;
        p = p >>> FRAC;
        return IW'(p);
    endfunction

    // Saturate a signed window coordinate into [0, PATCH-1].
    function automatic logic [CW-1:0] clamp_pos(input logic signed [IW-1:0] v);
        logic [CW-1:0] r;
        if (v < 0)            r = '0;
        else if (v > PMAX_S)  r = CW'(PMAX_S);
        else                  r = CW'(v);
        return r;
    endfunction

    // Rotated column: x*cos - y*sin, re-centred on the window.
    function automatic logic [CW-1:0] rot_col(input logic signed [7:0] x, input logic signed [7:0] y,
                                              input logic signed [TRIG_W-1:0] c,
                                              input logic signed [TRIG_W-1:0] s);
        return clamp_pos(mul_trunc(x, c) - mul_trunc(y, s) + RAD_S);
    endfunction

    // Rotated row: x*sin + y*cos, re-centred on the window.
    function automatic logic [CW-1:0] rot_row(input logic signed [7:0] x, input logic signed [7:0] y,
                                              input logic signed [TRIG_W-1:0] c,
                                              input logic signed [TRIG_W-1:0] s);
        return clamp_pos(mul_trunc(x, s) + mul_trunc(y, c) + RAD_S);
    endfunction

    // Bit offset of pixel(r,c) in the packed window.
    function automatic logic [WAW-1:0] pix_base(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return WAW'((int'(r) * PATCH + int'(c)) * 8);
    endfunction

    // Descriptor bit index for lane l of a given beat.
    function automatic logic [DW-1:0] bit_pos(input logic [PAT_AW-1:0] beat, input int l);
        return DW'(int'(beat) * LANES + l);
    endfunction

    logic [1:0]               state_q, state_d;
    logic [PAT_AW-1:0]        beat_q, beat_d;
    logic [WIN_W-1:0]         win_q, win_d;
    logic [9:0]               coor_x_q, coor_x_d;
    logic [9:0]               coor_y_q, coor_y_d;
    logic [7:0]               score_q, score_d;
    logic signed [TRIG_W-1:0] sin_q, sin_d;
    logic signed [TRIG_W-1:0] cos_q, cos_d;
    logic                     pat_vld_q, pat_vld_d;
    logic [PAT_AW-1:0]        pat_beat_q, pat_beat_d;
    logic                     vld_a_q, vld_a_d;
    logic [PAT_AW-1:0]        beat_a_q, beat_a_d;
    logic [LANES*CW-1:0]      xa_q, xa_d, ya_q, ya_d, xb_q, xb_d, yb_q, yb_d;
    logic [DESC_BITS-1:0]     desc_q, desc_d;
    logic                     accept;
    logic                     zero_coor;

    assign o_ready      = (state_q == ST_IDLE) || ((state_q == ST_OUT) && i_ready);
    assign accept       = i_valid && o_ready;
    assign zero_coor    = (i_coor_x == '0) || (i_coor_y == '0);
    assign o_valid      = (state_q == ST_OUT);
    assign o_pat_addr   = (state_q == ST_FETCH) ? beat_q : '0;
    assign o_coor_x     = coor_x_q;
    assign o_coor_y     = coor_y_q;
    assign o_score      = score_q;
    assign o_descriptor = desc_q;

    // Job sequencing: IDLE -> FETCH (BEATS beats) -> DRAIN (2 cycles) -> OUT.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        pat_vld_d  = (state_q == ST_FETCH);
        pat_beat_d = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = zero_coor ? ST_IDLE : ST_FETCH;
                beat_d = '0;
            end
            ST_FETCH: begin
                if (beat_q == PAT_AW'(BEATS - 1)) begin
                    state_d = ST_DRAIN;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (beat_q == PAT_AW'(1)) begin
                    state_d = ST_OUT;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (i_ready) state_d = (accept && !zero_coor) ? ST_FETCH : ST_IDLE;
                beat_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Job capture on accept; an unsteered job gets the identity rotation.
    always_comb begin
        win_d    = win_q;
        coor_x_d = coor_x_q;
        coor_y_d = coor_y_q;
        score_d  = score_q;
        sin_d    = sin_q;
        cos_d    = cos_q;
        if (accept) begin
            win_d    = i_window;
            coor_x_d = i_coor_x - 10'(X_OFFSET);
            coor_y_d = i_coor_y;
            score_d  = i_score;
            sin_d    = i_rot_en ? i_sin : '0;
            cos_d    = i_rot_en ? i_cos : TRIG_W'(1 << FRAC);
        end
    end

    // Stage A: rotate and clamp the pattern beat returned by the ROM.
    always_comb begin
        xa_d     = xa_q;
        ya_d     = ya_q;
        xb_d     = xb_q;
        yb_d     = yb_q;
        vld_a_d  = pat_vld_q;
        beat_a_d = beat_a_q;
        if (pat_vld_q) begin
            beat_a_d = pat_beat_q;
            for (int l = 0; l < LANES; l++) begin
                xa_d[l*CW +: CW] = rot_col(i_pat[l*32+24 +: 8], i_pat[l*32+16 +: 8], cos_q, sin_q);
                ya_d[l*CW +: CW] = rot_row(i_pat[l*32+24 +: 8], i_pat[l*32+16 +: 8], cos_q, sin_q);
                xb_d[l*CW +: CW] = rot_col(i_pat[l*32+8 +: 8], i_pat[l*32 +: 8], cos_q, sin_q);
                yb_d[l*CW +: CW] = rot_row(i_pat[l*32+8 +: 8], i_pat[l*32 +: 8], cos_q, sin_q);
            end
        end
    end

    // Stage B: pixel comparisons write one beat of descriptor bits; accept clears.
    always_comb begin
        desc_d = desc_q;
        if (accept) begin
            desc_d = '0;
        end else if (vld_a_q) begin
            for (int l = 0; l < LANES; l++) begin
                desc_d[bit_pos(beat_a_q, l)] =
                    win_q[pix_base(ya_q[l*CW +: CW], xa_q[l*CW +: CW]) +: 8] >
                    win_q[pix_base(yb_q[l*CW +: CW], xb_q[l*CW +: CW]) +: 8];
            end
        end
    end

    // All state registers; reset abandons any job in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            win_q      <= '0;
            coor_x_q   <= '0;
            coor_y_q   <= '0;
            score_q    <= '0;
            sin_q      <= '0;
            cos_q      <= '0;
            pat_vld_q  <= 1'b0;
            pat_beat_q <= '0;
            vld_a_q    <= 1'b0;
            beat_a_q   <= '0;
            xa_q       <= '0;
            ya_q       <= '0;
            xb_q       <= '0;
            yb_q       <= '0;
            desc_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            win_q      <= win_d;
            coor_x_q   <= coor_x_d;
            coor_y_q   <= coor_y_d;
            score_q    <= score_d;
            sin_q      <= sin_d;
            cos_q      <= cos_d;
            pat_vld_q  <= pat_vld_d;
            pat_beat_q <= pat_beat_d;
            vld_a_q    <= vld_a_d;
            beat_a_q   <= beat_a_d;
            xa_q       <= xa_d;
            ya_q       <= ya_d;
            xb_q       <= xb_d;
            yb_q       <= yb_d;
            desc_q     <= desc_d;
        end
    end

endmodule

// File: tb/tb_brief_engine_tm.sv
// Testbench for brief_engine_tm: a synchronous pattern ROM model plus a
// descriptor reference model computed directly from the rotation rules.
module tb_brief_engine_tm;

    localparam int PATCH     = 31;
    localparam int DESC_BITS = 256;
    localparam int LANES     = 32;
    localparam int TRIG_W    = 12;
    localparam int FRAC      = 10;
    localparam int X_OFFSET  = 2;
    localparam int BEATS     = DESC_BITS / LANES;
    localparam int PAW       = 3;
    localparam int WIN_W     = PATCH * PATCH * 8;
    localparam int RAD       = (PATCH - 1) / 2;

    logic                     clk, rst_n, i_valid, o_ready, i_rot_en, o_valid, i_ready;
    logic [WIN_W-1:0]         i_window;
    logic [9:0]               i_coor_x, i_coor_y, o_coor_x, o_coor_y;
    logic [7:0]               i_score, o_score;
    logic signed [TRIG_W-1:0] i_sin, i_cos;
    logic [PAW-1:0]           o_pat_addr;
    logic [LANES*32-1:0]      i_pat;
    logic [DESC_BITS-1:0]     o_descriptor;

    int total = 0;
    int bad   = 0;
    int pix [PATCH][PATCH];
    logic [LANES*32-1:0] rom [BEATS];

    brief_engine_tm #(
        .PATCH(PATCH), .DESC_BITS(DESC_BITS), .LANES(LANES),
        .TRIG_W(TRIG_W), .FRAC(FRAC), .X_OFFSET(X_OFFSET)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_window(i_window), .i_coor_x(i_coor_x), .i_coor_y(i_coor_y),
        .i_score(i_score), .i_sin(i_sin), .i_cos(i_cos), .i_rot_en(i_rot_en),
        .o_pat_addr(o_pat_addr), .i_pat(i_pat), .o_valid(o_valid),
        .i_ready(i_ready), .o_coor_x(o_coor_x), .o_coor_y(o_coor_y),
        .o_score(o_score), .o_descriptor(o_descriptor)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pattern ROM: data for an address appears one cycle later.
    always @(posedge clk) i_pat <= rom[o_pat_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > PATCH - 1) return PATCH - 1;
        return v;
    endfunction

    // Reference descriptor. SV integer division truncates toward zero, as required.
    function automatic logic [DESC_BITS-1:0] model_desc(input bit rot, input int s, input int c);
        logic [DESC_BITS-1:0] d;
        logic [31:0] w;
        int cs, sn, xa, ya, xb, yb, pxa, pya, pxb, pyb, one;
        one = 1 << FRAC;
        cs  = rot ? c : one;
        sn  = rot ? s : 0;
        d   = '0;
        for (int k = 0; k < DESC_BITS; k++) begin
            w   = rom[k / LANES][(k % LANES) * 32 +: 32];
            xa  = int'($signed(w[31:24]));
            ya  = int'($signed(w[23:16]));
            xb  = int'($signed(w[15:8]));
            yb  = int'($signed(w[7:0]));
            pxa = clampi((xa * cs) / one - (ya * sn) / one + RAD);
            pya = clampi((xa * sn) / one + (ya * cs) / one + RAD);
            pxb = clampi((xb * cs) / one - (yb * sn) / one + RAD);
            pyb = clampi((xb * sn) / one + (yb * cs) / one + RAD);
            d[k] = pix[pya][pxa] > pix[pyb][pxb];
        end
        return d;
    endfunction

    task automatic pack_window();
        for (int r = 0; r < PATCH; r++)
            for (int c = 0; c < PATCH; c++)
                i_window[(r * PATCH + c) * 8 +: 8] = 8'(pix[r][c]);
    endtask

    task automatic rand_window();
        for (int r = 0; r < PATCH; r++)
            for (int c = 0; c < PATCH; c++)
                pix[r][c] = int'($urandom_range(0, 255));
    endtask

    task automatic rand_rom();
        for (int b = 0; b < BEATS; b++)
            for (int l = 0; l < LANES; l++)
                rom[b][l * 32 +: 32] = $urandom();
    endtask

    task automatic clear_rom();
        for (int b = 0; b < BEATS; b++) rom[b] = '0;
    endtask

    task automatic set_pair(input int k, input int xa, input int ya, input int xb, input int yb);
        rom[k / LANES][(k % LANES) * 32 +: 32] = {8'(xa), 8'(ya), 8'(xb), 8'(yb)};
    endtask

    task automatic drive_job(input int x, input int y, input int sc, input bit rot,
                             input int s, input int c);
        pack_window();
        i_coor_x = 10'(x);
        i_coor_y = 10'(y);
        i_score  = 8'(sc);
        i_rot_en = rot;
        i_sin    = TRIG_W'(s);
        i_cos    = TRIG_W'(c);
        i_valid  = 1'b1;
    endtask

    // Offer a job, wait for its accept, then count edges until o_valid (-1: never accepted).
    task automatic run_job(input int x, input int y, input int sc, input bit rot,
                           input int s, input int c, output int lat);
        int n;
        bit acc;
        drive_job(x, y, sc, rot, s, c);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            if (o_ready) begin
                @(posedge clk);
                acc = 1'b1;
            end
            n++;
        end
        #1 i_valid = 1'b0;
        lat = 0;
        if (acc) begin
            while (!o_valid && lat < 50) begin
                @(posedge clk);
                #1;
                lat++;
            end
        end else begin
            lat = -1;
        end
    endtask

    task automatic finish_out();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({o_valid, o_coor_x, o_coor_y, o_score, o_pat_addr} !== '0) begin
            bad++;
            $display("FAIL reset_outs: got v=%0b x=%0d y=%0d s=%0d a=%0d want all 0",
                     o_valid, o_coor_x, o_coor_y, o_score, o_pat_addr);
        end
        total++;
        if (o_descriptor !== '0) begin
            bad++;
            $display("FAIL reset_desc: got %h want 0", o_descriptor);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", o_ready);
        end
    endtask

    task automatic test_flat_window();
        int lat;
        for (int r = 0; r < PATCH; r++)
            for (int c = 0; c < PATCH; c++)
                pix[r][c] = 8'h40;
        rand_rom();
        run_job(100, 50, 77, 1'b0, 0, 0, lat);
        total++;
        if (lat !== 10) begin
            bad++;
            $display("FAIL flat_latency: got %0d want 10", lat);
        end
        total++;
        if (o_descriptor !== '0) begin
            bad++;
            $display("FAIL flat_desc: got %h want 0", o_descriptor);
        end
        total++;
        if ({o_coor_x, o_coor_y, o_score} !== {10'd98, 10'd50, 8'd77}) begin
            bad++;
            $display("FAIL flat_meta: got x=%0d y=%0d s=%0d want 98 50 77", o_coor_x, o_coor_y, o_score);
        end
        finish_out();
        total++;
        if ({o_valid, o_ready} !== 2'b01) begin
            bad++;
            $display("FAIL flat_release: got valid=%b ready=%b want 0 1", o_valid, o_ready);
        end
    endtask

    task automatic test_single_pair();
        int lat;
        for (int r = 0; r < PATCH; r++)
            for (int c = 0; c < PATCH; c++)
                pix[r][c] = c * 8;
        clear_rom();
        set_pair(0, 5, 0, -5, 0);
        run_job(10, 20, 1, 1'b0, 0, 0, lat);
        total++;
        if (lat !== 10 || o_descriptor !== DESC_BITS'(1)) begin
            bad++;
            $display("FAIL pair_unrot: got lat=%0d desc=%h want 10 and bit0 only", lat, o_descriptor);
        end
        finish_out();
        run_job(10, 20, 1, 1'b1, 0, -1024, lat);
        total++;
        if (lat !== 10 || o_descriptor !== '0) begin
            bad++;
            $display("FAIL pair_flip: got lat=%0d desc=%h want 10 and 0", lat, o_descriptor);
        end
        finish_out();
    endtask

    task automatic test_clamp();
        int lat;
        rand_window();
        clear_rom();
        set_pair(0, 15, -15, 0, 0);
        pix[15][30] = 200;
        pix[15][15] = 100;
        run_job(64, 64, 3, 1'b1, 724, 724, lat);
        total++;
        if (lat !== 10 || o_descriptor !== DESC_BITS'(1)) begin
            bad++;
            $display("FAIL clamp_hi: got lat=%0d desc=%h want 10 and bit0 only", lat, o_descriptor);
        end
        finish_out();
        pix[15][30] = 50;
        run_job(64, 64, 3, 1'b1, 724, 724, lat);
        total++;
        if (lat !== 10 || o_descriptor !== '0) begin
            bad++;
            $display("FAIL clamp_lo: got lat=%0d desc=%h want 10 and 0", lat, o_descriptor);
        end
        finish_out();
    endtask

    task automatic test_random();
        int lat, x, y, sc, s, c;
        bit rot;
        logic [DESC_BITS-1:0] exp;
        for (int j = 0; j < 8; j++) begin
            rand_window();
            rand_rom();
            x   = (j == 0) ? 1 : int'($urandom_range(1, 1023));
            y   = int'($urandom_range(1, 1023));
            sc  = int'($urandom_range(0, 255));
            rot = (j % 4 != 3);
            s   = int'($urandom_range(0, 4095)) - 2048;
            c   = int'($urandom_range(0, 4095)) - 2048;
            exp = model_desc(rot, s, c);
            run_job(x, y, sc, rot, s, c, lat);
            total++;
            if (lat !== 10) begin
                bad++;
                $display("FAIL rand_latency[%0d]: got %0d want 10", j, lat);
            end
            total++;
            if (o_descriptor !== exp) begin
                bad++;
                $display("FAIL rand_desc[%0d]: got %h want %h", j, o_descriptor, exp);
            end
            total++;
            if ({o_coor_x, o_coor_y, o_score} !== {10'(x - X_OFFSET), 10'(y), 8'(sc)}) begin
                bad++;
                $display("FAIL rand_meta[%0d]: got x=%0d y=%0d s=%0d want %0d %0d %0d",
                         j, o_coor_x, o_coor_y, o_score, (x - X_OFFSET) & 1023, y, sc);
            end
            finish_out();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [DESC_BITS-1:0] exp_a, exp_b;
        rand_window();
        rand_rom();
        exp_a = model_desc(1'b1, 300, -900);
        i_ready = 1'b0;
        run_job(300, 400, 9, 1'b1, 300, -900, lat);
        total++;
        if (lat !== 10) begin
            bad++;
            $display("FAIL bp_latency_a: got %0d want 10", lat);
        end
        rand_window();
        exp_b = model_desc(1'b0, 0, 0);
        drive_job(2, 7, 200, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({o_valid, o_ready, o_descriptor, o_coor_x, o_coor_y, o_score} !==
                {1'b1, 1'b0, exp_a, 10'd298, 10'd400, 8'd9}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b r=%b x=%0d y=%0d s=%0d desc=%h want 1 0 298 400 9 %h",
                         i, o_valid, o_ready, o_coor_x, o_coor_y, o_score, o_descriptor, exp_a);
            end
            @(posedge clk);
            #1;
        end
        i_ready = 1'b1;
        @(negedge clk);
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready_comb: got %b want 1", o_ready);
        end
        @(posedge clk);
        #1 i_valid = 1'b0;
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_transfer: got valid=%b want 0", o_valid);
        end
        lat = 0;
        while (!o_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++;
        if (lat !== 10) begin
            bad++;
            $display("FAIL bp_latency_b: got %0d want 10", lat);
        end
        total++;
        if ({o_descriptor, o_coor_x, o_coor_y, o_score} !== {exp_b, 10'd0, 10'd7, 8'd200}) begin
            bad++;
            $display("FAIL bp_job_b: got x=%0d y=%0d s=%0d desc=%h want 0 7 200 %h",
                     o_coor_x, o_coor_y, o_score, o_descriptor, exp_b);
        end
        finish_out();
    endtask

    task automatic test_zero_drop();
        bit seen;
        for (int k = 0; k < 2; k++) begin
            rand_window();
            drive_job((k == 0) ? 0 : 33, (k == 0) ? 40 : 0, 5, 1'b0, 0, 0);
            @(negedge clk);
            @(posedge clk);
            #1 i_valid = 1'b0;
            total++;
            if (o_ready !== 1'b1) begin
                bad++;
                $display("FAIL zero_ready[%0d]: got %b want 1", k, o_ready);
            end
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (o_valid !== 1'b0 || o_pat_addr !== '0) seen = 1'b1;
            end
            total++;
            if (seen !== 1'b0) begin
                bad++;
                $display("FAIL zero_no_output[%0d]: got activity=%b want 0", k, seen);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_job();
        int n, lat;
        logic [DESC_BITS-1:0] exp;
        rand_window();
        rand_rom();
        drive_job(123, 45, 66, 1'b1, -500, 800);
        @(negedge clk);
        @(posedge clk);
        #1 i_valid = 1'b0;
        n = 0;
        while (o_pat_addr !== 3'd3 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL mid_beat3: got %0d edges want 3", n);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({o_valid, o_coor_x, o_coor_y, o_score, o_pat_addr, o_descriptor} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outs: got v=%b x=%0d y=%0d s=%0d a=%0d desc=%h want all 0",
                     o_valid, o_coor_x, o_coor_y, o_score, o_pat_addr, o_descriptor);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_ready: got %b want 1", o_ready);
        end
        rand_window();
        rand_rom();
        exp = model_desc(1'b1, 1000, -200);
        run_job(77, 88, 11, 1'b1, 1000, -200, lat);
        total++;
        if (lat !== 10 || o_descriptor !== exp) begin
            bad++;
            $display("FAIL mid_next_job: got lat=%0d desc=%h want 10 %h", lat, o_descriptor, exp);
        end
        finish_out();
    endtask

    initial begin
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        i_rot_en = 1'b0;
        i_coor_x = '0;
        i_coor_y = '0;
        i_score  = '0;
        i_sin    = '0;
        i_cos    = '0;
        i_window = '0;
        clear_rom();
        test_reset();
        test_flat_window();
        test_single_pair();
        test_clamp();
        test_random();
        test_back_to_back();
        test_zero_drop();
        test_reset_mid_job();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/brief_engine_tm.md
Name: brief_engine_tm

Overview:
Parametrised, time-multiplexed, steered BRIEF descriptor engine for the ORB front end. It sits after the FAST/orientation stages. It accepts one keypoint job at a time: a pixel window plus keypoint metadata and sin/cos. It evaluates DESC_BITS rotated test pairs over several cycles, with LANES pairs per cycle, fetched from an external pattern ROM. It emits the descriptor over a valid/ready handshake. LANES trades area for latency. Rotation can be bypassed per job.

Parameters:
PATCH, 31, window side in pixels (odd); RAD=(PATCH-1)/2 is the centre index
DESC_BITS, 256, descriptor length
LANES, 32, test pairs evaluated per cycle; power of two; DESC_BITS%LANES==0
TRIG_W, 12, signed sin/cos width
FRAC, 10, fractional bits of sin/cos
X_OFFSET, 2, subtracted from the accepted x coordinate on output
BEATS, DESC_BITS/LANES, derived; do not override

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  job offered
o_ready  out  1  job accepted when i_valid&&o_ready at posedge
i_window  in  PATCH*PATCH*8  pixel(r,c) at bits [(r*PATCH+c)*8 +: 8]
i_coor_x  in  10  keypoint x
i_coor_y  in  10  keypoint y
i_score  in  8  keypoint score
i_sin  in  TRIG_W  signed sine, Q(FRAC)
i_cos  in  TRIG_W  signed cosine, Q(FRAC)
i_rot_en  in  1  1: steered; 0: unrotated pattern
o_pat_addr  out  log2(BEATS) (min 1)  pattern ROM beat address
i_pat  in  LANES*32  lane l at [l*32 +: 32] = {xa,ya,xb,yb}, each signed 8b; returned 1 cycle after o_pat_addr
o_valid  out  1  descriptor available
i_ready  in  1  downstream accepts
o_coor_x  out  10  i_coor_x - X_OFFSET (mod 2^10)
o_coor_y  out  10  i_coor_y
o_score  out  8  latched score
o_descriptor  out  DESC_BITS  bit k = result of pair k

Behaviour:
- Clock i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset: state IDLE, beat counter 0, all registers 0. Outputs: o_valid=0, o_descriptor=0, o_coor_x/y=0, o_score=0, o_pat_addr=0. o_ready=1 after release.
- States: IDLE, FETCH, DRAIN, OUT.
- o_ready = (IDLE) || (OUT && i_ready). It is combinational on i_ready.
- Accept: latch the window, coordinates, score, sin and cos. When i_rot_en=0, latch cos=1<<FRAC and sin=0.
- Zero-coordinate drop: if the accepted i_coor_x==0 or i_coor_y==0, the job is discarded. The engine returns to or stays in IDLE and produces no o_valid.
- FETCH lasts BEATS cycles, with o_pat_addr = beat 0..BEATS-1.
- Stage A, the cycle after an address: i_pat valid.
  - Per lane, compute the four products p = coord*trig, each truncated toward zero after >>>FRAC.
  - x' = xc - ys + RAD; y' = xs + yc + RAD, where xc = trunc(x*cos), ys = trunc(y*sin), xs = trunc(x*sin), yc = trunc(y*cos).
  - Compute with at least 10-bit signed intermediate, clamp to [0, PATCH-1], and register.
- Stage B: sample pixel(y'a,x'a) and pixel(y'b,x'b). Descriptor bit beat*LANES+l = (pa > pb), strict unsigned compare. Register it.
- DRAIN lasts 2 cycles to flush stages A/B. It then enters OUT with o_valid=1.
- Latency: o_valid rises BEATS+2 cycles after the accept edge (10 with defaults).
- OUT: o_descriptor, o_coor_x/y and o_score stay stable while o_valid && !i_ready. On i_ready the transfer completes.
  - If i_valid is also high, the new job is accepted the same edge and the state goes to FETCH; o_valid falls.
  - Otherwise the state goes to IDLE.
- The descriptor register is cleared on accept. Bits not yet written read 0 and are not observable, since o_valid=0.
- i_pat is ignored outside the cycle after a FETCH address. o_pat_addr holds 0 outside FETCH.
- Reset mid-job: the job is abandoned and no output is produced.

Test Plan:
1. Window all 0x40, rot_en=0, any pattern, coor (100,50), score 77. Required: o_valid exactly 10 cycles after accept; descriptor all 0; o_coor_x=98, o_coor_y=50, o_score=77.
2. Window pixel(r,c)=c*8; pair 0 = {5,0,-5,0}, all other pairs {0,0,0,0}; rot_en=0. Required: bit0=1, others 0. Repeat with rot_en=1, cos=-1024, sin=0. Required: bit0=0.
3. Clamp: pair 0 = {15,-15,0,0}, sin=cos=724. Required: x'a = 10+10+15 = 35, clamped to 30; y'a = 15. Bit0 equals (pixel(15,30) > pixel(15,15)).
4. Backpressure: hold i_ready=0 for 5 cycles in OUT with i_valid=1 and a new job. Required: outputs stable, o_ready=0, no accept. Then raise i_ready. Required: transfer and new accept on the same edge; next o_valid 10 cycles later.
5. Offer a job with i_coor_x=0. Required: accepted, no o_valid ever, o_ready=1 on the next cycle.
6. Assert i_rst_n=0 during FETCH beat 3. Required: all outputs 0 immediately, o_ready=1 after release, and the next job produces the correct descriptor.
